// File: rtl/arp_receiver_if.sv
// Handshake bundle between the Ethernet receiver, arp_receiver and the ARP cache/responder.
// The master side drives the byte stream and consumes events; the slave side is the parser.
interface arp_receiver_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  arp_rx_tvalid;
    logic [DATA_WIDTH-1:0] arp_rx_tdata;
    logic                  arp_rx_tlast;
    logic                  arp_rx_tready;
    logic                  arp_event_valid;
    logic                  arp_event_ready;
    logic [15:0]           arp_opcode;
    logic [47:0]           arp_sender_mac;
    logic [31:0]           arp_sender_ip;
    logic [31:0]           arp_target_ip;

    modport master (
        output arp_rx_tvalid, arp_rx_tdata, arp_rx_tlast, arp_event_ready,
        input  arp_rx_tready, arp_event_valid, arp_opcode, arp_sender_mac,
               arp_sender_ip, arp_target_ip
    );

    modport slave (
        input  arp_rx_tvalid, arp_rx_tdata, arp_rx_tlast, arp_event_ready,
        output arp_rx_tready, arp_event_valid, arp_opcode, arp_sender_mac,
               arp_sender_ip, arp_target_ip
    );
endinterface

// File: rtl/arp_receiver.sv
// Parses the 28-byte IPv4-over-Ethernet ARP body, validates it against the local IP and
// presents one decoded event per accepted packet; rejected frames bump a saturating counter.
module arp_receiver #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned ARP_PACKET_BYTES = 28,
    parameter logic [15:0] HW_TYPE          = 16'h0001,
    parameter logic [15:0] PROTO_TYPE       = 16'h0800
) (
    input  logic                clock,
    input  logic                reset,
    arp_receiver_if.slave       arp,
    input  logic [31:0]         local_ip_address,
    output logic [15:0]         arp_drop_count
);
    localparam logic [1:0] RECEIVE = 2'd0;
    localparam logic [1:0] DRAIN   = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    localparam logic [4:0] PACKET_BYTES = 5'(ARP_PACKET_BYTES);
    localparam logic [4:0] LAST_INDEX   = 5'(ARP_PACKET_BYTES - 1);

    logic [1:0]  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        error_q, error_d;
    logic [7:0]  prev_q, prev_d;
    logic [15:0] oper_q, oper_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic [31:0] tpa_q, tpa_d;
    logic        valid_q, valid_d;
    logic [15:0] opcode_q, opcode_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] sip_q, sip_d;
    logic [31:0] tip_q, tip_d;
    logic [15:0] drop_q, drop_d;

    logic [7:0]  rx_byte;
    logic [15:0] rx_word;
    logic        beat;
    logic        field_bad;
    logic [31:0] tpa_full;
    logic [15:0] drop_inc;

    assign rx_byte  = arp.arp_rx_tdata[7:0];
    assign rx_word  = {prev_q, rx_byte};
    assign beat     = arp.arp_rx_tvalid && arp.arp_rx_tready;
    assign drop_inc = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
    // The final TPA byte may be the tlast byte itself, so fold it in before comparing.
    assign tpa_full = (count_q == LAST_INDEX) ? {tpa_q[23:0], rx_byte} : tpa_q;

    always_comb begin
        field_bad = 1'b0;
        case (count_q)
            5'd1:    field_bad = (rx_word != HW_TYPE);
            5'd3:    field_bad = (rx_word != PROTO_TYPE);
            5'd4:    field_bad = (rx_byte != 8'd6);
            5'd5:    field_bad = (rx_byte != 8'd4);
            5'd7:    field_bad = (rx_word != 16'd1) && (rx_word != 16'd2);
            default: field_bad = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        error_d  = error_q;
        prev_d   = prev_q;
        oper_d   = oper_q;
        sha_d    = sha_q;
        spa_d    = spa_q;
        tpa_d    = tpa_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        mac_d    = mac_q;
        sip_d    = sip_q;
        tip_d    = tip_q;
        drop_d   = drop_q;
        case (state_q)
            RECEIVE: begin
                if (beat) begin
                    prev_d = rx_byte;
                    if (count_q == 5'd6 || count_q == 5'd7) oper_d = {oper_q[7:0], rx_byte};
                    if (count_q >= 5'd8 && count_q <= 5'd13) sha_d = {sha_q[39:0], rx_byte};
                    if (count_q >= 5'd14 && count_q <= 5'd17) spa_d = {spa_q[23:0], rx_byte};
                    if (count_q >= 5'd24 && count_q <= 5'd27) tpa_d = {tpa_q[23:0], rx_byte};
                    if (arp.arp_rx_tlast) begin
                        count_d = 5'd0;
                        error_d = 1'b0;
                        if (!field_bad && count_q >= LAST_INDEX && tpa_full == local_ip_address)
                        begin
                            valid_d  = 1'b1;
                            opcode_d = oper_q;
                            mac_d    = sha_q;
                            sip_d    = spa_q;
                            tip_d    = tpa_full;
                            state_d  = HOLD;
                        end else begin
                            drop_d = drop_inc;
                        end
                    end else if (field_bad) begin
                        error_d = 1'b1;
                        state_d = DRAIN;
                    end else if (count_q != PACKET_BYTES) begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                if (beat && arp.arp_rx_tlast) begin
                    drop_d  = drop_inc;
                    count_d = 5'd0;
                    error_d = 1'b0;
                    state_d = RECEIVE;
                end
            end
            HOLD: begin
                if (arp.arp_event_ready) begin
                    valid_d = 1'b0;
                    state_d = RECEIVE;
                end
            end
            default: state_d = RECEIVE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= RECEIVE;
            count_q  <= 5'd0;
            error_q  <= 1'b0;
            prev_q   <= 8'd0;
            oper_q   <= 16'd0;
            sha_q    <= 48'd0;
            spa_q    <= 32'd0;
            tpa_q    <= 32'd0;
            valid_q  <= 1'b0;
            opcode_q <= 16'd0;
            mac_q    <= 48'd0;
            sip_q    <= 32'd0;
            tip_q    <= 32'd0;
            drop_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            error_q  <= error_d;
            prev_q   <= prev_d;
            oper_q   <= oper_d;
            sha_q    <= sha_d;
            spa_q    <= spa_d;
            tpa_q    <= tpa_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            mac_q    <= mac_d;
            sip_q    <= sip_d;
            tip_q    <= tip_d;
            drop_q   <= drop_d;
        end
    end

    assign arp.arp_rx_tready   = !reset && (state_q != HOLD);
    assign arp.arp_event_valid = valid_q;
    assign arp.arp_opcode      = opcode_q;
    assign arp.arp_sender_mac  = mac_q;
    assign arp.arp_sender_ip   = sip_q;
    assign arp.arp_target_ip   = tip_q;
    assign arp_drop_count      = drop_q;
endmodule

// File: tb/tb_arp_receiver.sv
// Scoreboard bench for arp_receiver: expected events are queued as frames are driven and
// compared when the DUT hands an event over.
module tb_arp_receiver;
    localparam logic [31:0] LOCAL_IP = 32'h0A00_0001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] local_ip_address;
    logic [15:0] arp_drop_count;

    arp_receiver_if ifc ();

    arp_receiver dut (
        .clock            (clock),
        .reset            (reset),
        .arp              (ifc),
        .local_ip_address (local_ip_address),
        .arp_drop_count   (arp_drop_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] opcode;
        logic [47:0] mac;
        logic [31:0] sip;
        logic [31:0] tip;
    } event_t;

    event_t     expected_q[$];
    event_t     mon_evt;
    event_t     held_evt;
    logic [7:0] frame[$];
    int         checks = 0;
    int         errors = 0;
    int         events_seen = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [15:0] htype, input logic [15:0] ptype,
                         input logic [15:0] oper, input logic [47:0] sha,
                         input logic [31:0] spa, input logic [31:0] tpa, input int pad);
        frame.delete();
        frame.push_back(htype[15:8]); frame.push_back(htype[7:0]);
        frame.push_back(ptype[15:8]); frame.push_back(ptype[7:0]);
        frame.push_back(8'd6);        frame.push_back(8'd4);
        frame.push_back(oper[15:8]);  frame.push_back(oper[7:0]);
        for (int i = 5; i >= 0; i--) frame.push_back(sha[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) frame.push_back(spa[i*8 +: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(8'hEE);
        for (int i = 3; i >= 0; i--) frame.push_back(tpa[i*8 +: 8]);
        for (int i = 0; i < pad; i++) frame.push_back(8'(8'hA0 + i));
    endtask

    task automatic push_event(input logic [15:0] oper, input logic [47:0] sha,
                              input logic [31:0] spa, input logic [31:0] tpa);
        expected_q.push_back({oper, sha, spa, tpa});
    endtask

    // Called on a falling edge; returns on the falling edge after the last transfer.
    task automatic send_frame(input int nbytes, input bit with_last, input bit expect_event);
        int waited;
        for (int i = 0; i < nbytes; i++) begin
            ifc.arp_rx_tvalid = 1'b1;
            ifc.arp_rx_tdata  = frame[i];
            ifc.arp_rx_tlast  = with_last && (i == nbytes - 1);
            waited = 0;
            while (!ifc.arp_rx_tready && waited < 200) begin
                @(negedge clock);
                waited++;
            end
            if (!ifc.arp_rx_tready) begin
                check("tready_timeout", 0, 1);
                ifc.arp_rx_tvalid = 1'b0;
                ifc.arp_rx_tlast  = 1'b0;
                return;
            end
            @(negedge clock);
        end
        ifc.arp_rx_tvalid = 1'b0;
        ifc.arp_rx_tlast  = 1'b0;
        if (with_last) check("event_latency", ifc.arp_event_valid, expect_event);
    endtask

    always @(negedge clock) begin
        if (!reset && ifc.arp_event_valid && ifc.arp_event_ready) begin
            if (expected_q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                mon_evt = expected_q.pop_front();
                check("opcode", ifc.arp_opcode, mon_evt.opcode);
                check("sender_mac", ifc.arp_sender_mac, mon_evt.mac);
                check("sender_ip", ifc.arp_sender_ip, mon_evt.sip);
                check("target_ip", ifc.arp_target_ip, mon_evt.tip);
                events_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.arp_rx_tvalid   = 1'b0;
        ifc.arp_rx_tdata    = 8'd0;
        ifc.arp_rx_tlast    = 1'b0;
        ifc.arp_event_ready = 1'b1;
        local_ip_address    = LOCAL_IP;
        repeat (2) @(negedge clock);
        check("reset_tready", ifc.arp_rx_tready, 0);
        check("reset_valid", ifc.arp_event_valid, 0);
        check("reset_opcode", ifc.arp_opcode, 0);
        check("reset_mac", ifc.arp_sender_mac, 0);
        check("reset_tip", ifc.arp_target_ip, 0);
        check("reset_drops", arp_drop_count, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_tready", ifc.arp_rx_tready, 1);

        // Plain request for this node
        build(16'h0001, 16'h0800, 16'd1, 48'h0200_0000_0001, 32'h0A00_0002, LOCAL_IP, 0);
        push_event(16'd1, 48'h0200_0000_0001, 32'h0A00_0002, LOCAL_IP);
        send_frame(28, 1'b1, 1'b1);
        check("t1_drops", arp_drop_count, 0);
        @(negedge clock);
        check("t1_valid_cleared", ifc.arp_event_valid, 0);

        // Reply padded out to a 46-byte payload
        build(16'h0001, 16'h0800, 16'd2, 48'h0200_0000_0001, 32'h0A00_0002, LOCAL_IP, 18);
        push_event(16'd2, 48'h0200_0000_0001, 32'h0A00_0002, LOCAL_IP);
        send_frame(46, 1'b1, 1'b1);
        @(negedge clock);

        // Foreign TPA, then bad PTYPE
        build(16'h0001, 16'h0800, 16'd1, 48'h0200_0000_0001, 32'h0A00_0002, 32'h0A00_0009, 0);
        send_frame(28, 1'b1, 1'b0);
        check("t3_drops_tpa", arp_drop_count, 1);
        build(16'h0001, 16'h86DD, 16'd1, 48'h0200_0000_0001, 32'h0A00_0002, LOCAL_IP, 0);
        send_frame(28, 1'b1, 1'b0);
        check("t3_drops_ptype", arp_drop_count, 2);

        // Short frame ending on byte 20, then a good frame
        build(16'h0001, 16'h0800, 16'd1, 48'h0200_0000_0001, 32'h0A00_0002, LOCAL_IP, 0);
        send_frame(21, 1'b1, 1'b0);
        check("t4_drops_short", arp_drop_count, 3);
        build(16'h0001, 16'h0800, 16'd2, 48'h0A1B_2C3D_4E5F, 32'hC0A8_0105, LOCAL_IP, 0);
        push_event(16'd2, 48'h0A1B_2C3D_4E5F, 32'hC0A8_0105, LOCAL_IP);
        send_frame(28, 1'b1, 1'b1);
        check("t4_drops_after", arp_drop_count, 3);
        @(negedge clock);

        // Back-pressure: event held for 10 cycles while the next frame waits
        @(posedge clock);
        #1 ifc.arp_event_ready = 1'b0;
        @(negedge clock);
        held_evt = {16'd1, 48'h0211_2233_4455, 32'h0A00_0003, LOCAL_IP};
        build(16'h0001, 16'h0800, 16'd1, 48'h0211_2233_4455, 32'h0A00_0003, LOCAL_IP, 0);
        push_event(16'd1, 48'h0211_2233_4455, 32'h0A00_0003, LOCAL_IP);
        send_frame(28, 1'b1, 1'b1);
        build(16'h0001, 16'h0800, 16'd2, 48'h0266_7788_99AA, 32'h0A00_0004, LOCAL_IP, 0);
        push_event(16'd2, 48'h0266_7788_99AA, 32'h0A00_0004, LOCAL_IP);
        fork
            send_frame(28, 1'b1, 1'b1);
            begin
                for (int c = 0; c < 10; c++) begin
                    check("t5_tready_low", ifc.arp_rx_tready, 0);
                    check("t5_valid_held", ifc.arp_event_valid, 1);
                    check("t5_fields_stable", {ifc.arp_opcode, ifc.arp_sender_mac,
                          ifc.arp_sender_ip, ifc.arp_target_ip}, held_evt);
                    @(negedge clock);
                end
                @(posedge clock);
                #1 ifc.arp_event_ready = 1'b1;
            end
        join
        @(negedge clock);

        // Reset in the middle of a frame
        build(16'h0001, 16'h0800, 16'd1, 48'h0200_0000_0001, 32'h0A00_0002, LOCAL_IP, 0);
        send_frame(12, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("t6_tready", ifc.arp_rx_tready, 0);
        check("t6_valid", ifc.arp_event_valid, 0);
        check("t6_opcode", ifc.arp_opcode, 0);
        check("t6_mac", ifc.arp_sender_mac, 0);
        check("t6_drops", arp_drop_count, 0);
        reset = 1'b0;
        @(negedge clock);
        build(16'h0001, 16'h0800, 16'd2, 48'h02CA_FEBA_BE00, 32'h0A00_0007, LOCAL_IP, 0);
        push_event(16'd2, 48'h02CA_FEBA_BE00, 32'h0A00_0007, LOCAL_IP);
        send_frame(28, 1'b1, 1'b1);
        check("t6_drops_after", arp_drop_count, 0);

        repeat (3) @(negedge clock);
        check("queue_empty", expected_q.size(), 0);
        check("events_seen", events_seen, 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
